// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing for the FIFO read-side drain engine.
package fifo_rd_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int BUF_DEPTH      = 3;

  typedef logic [1:0] ptr_t;
  typedef logic [1:0] cnt_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Three-entry register skid buffer; clear drops contents but keeps storage.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DW = DATA_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  input  logic          clear,
  output logic [DW-1:0] rdata,
  output logic          valid,
  output cnt_t          count
);
  logic [DW-1:0] r_mem [BUF_DEPTH];
  ptr_t          r_wr_ptr, r_rd_ptr;
  cnt_t          r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({push, pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign valid = (r_count != '0);
  assign count = r_count;
endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the synchronous FIFO into a valid/ready stream using credit-based rd_en.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic                  err_underflow
);
  logic                 r_inflight, r_drop_pending, r_err;
  logic [CNT_WIDTH-1:0] r_words;
  cnt_t                 w_count;
  logic                 w_push, w_pop, w_valid;
  logic [2:0]           w_credit_used;

  // Credits count buffered plus in-flight words, so m_ready never reaches rd_en.
  assign w_credit_used = {1'b0, w_count} + {2'b00, r_inflight};
  assign fifo_rd_en    = rst_n && !fifo_empty && !flush && (w_credit_used < 3'(BUF_DEPTH));
  assign w_push        = r_inflight && !r_drop_pending && !fifo_underflow;
  assign w_pop         = w_valid && m_ready;

  fifo_rd_skid_buf #(.DW(DATA_WIDTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (fifo_data_out),
    .pop   (w_pop),
    .clear (flush),
    .rdata (m_data),
    .valid (w_valid),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight     <= 1'b0;
      r_drop_pending <= 1'b0;
      r_err          <= 1'b0;
      r_words        <= '0;
    end else begin
      r_inflight <= fifo_rd_en;
      // Lasts exactly one cycle: the slot in which a flushed read would return.
      r_drop_pending <= flush ? r_inflight : 1'b0;
      if (r_inflight && fifo_underflow) r_err <= 1'b1;
      if (w_pop) r_words <= r_words + 1'b1;
    end
  end

  assign m_valid       = w_valid;
  assign words_out     = r_words;
  assign err_underflow = r_err;

  a_credit: assert property (@(posedge clk) disable iff (!rst_n)
    w_credit_used <= 3'(BUF_DEPTH));
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized and directed bench for fifo_stream_reader against a queue-level model.
module tb_fifo_stream_reader;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        fifo_empty = 1'b1, fifo_underflow = 1'b0;
  logic [15:0] fifo_data_out = '0;
  logic        fifo_rd_en, m_valid, err_underflow;
  logic [15:0] m_data, words_out;
  logic        m_ready = 1'b0, flush = 1'b0;

  fifo_stream_reader #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
    .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .flush(flush), .words_out(words_out),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Model: fq is the FIFO contents, exp_q the words the stream still owes.
  logic [15:0] fq[$], exp_q[$];
  bit          mi, mi_uf, uf_inj, nxt_uf, err;
  logic [15:0] mi_data, nxt_data = '0;
  int          words, rd_pulses;

  task automatic step();
    bit exp_rd;
    fifo_data_out  = nxt_data;
    fifo_underflow = nxt_uf;
    fifo_empty     = (fq.size() == 0);
    #1;
    exp_rd = (fq.size() != 0) && !flush && ((exp_q.size() + int'(mi)) < 3);
    chk("rd_en", fifo_rd_en, exp_rd);
    chk("m_valid", m_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("m_data", m_data, exp_q[0]);
    chk("words_out", words_out, words & 32'hffff);
    chk("err", err_underflow, err);
    if (fifo_rd_en) rd_pulses++;
    if (exp_q.size() != 0 && m_ready) begin
      void'(exp_q.pop_front());
      words++;
    end
    if (mi && mi_uf) err = 1'b1;
    if (flush) exp_q.delete();
    else if (mi && !mi_uf) exp_q.push_back(mi_data);
    nxt_uf = 1'b0;
    mi     = exp_rd;
    mi_uf  = 1'b0;
    if (exp_rd) begin
      if (uf_inj) begin
        nxt_uf   = 1'b1;
        mi_uf    = 1'b1;
        nxt_data = 16'($urandom);
      end else begin
        mi_data  = fq.pop_front();
        nxt_data = mi_data;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    mi = 1'b0; mi_uf = 1'b0; nxt_uf = 1'b0; words = 0; err = 1'b0;
    fifo_underflow = 1'b0;
    fifo_empty = (fq.size() == 0);
    repeat (2) begin
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_words", words_out, 0);
      chk("rst_err", err_underflow, 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  task automatic load(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) fq.push_back(base + 16'(i));
  endtask

  initial begin
    int wait_cyc;
    logic [15:0] w_before;
    @(negedge clk);
    do_reset();

    // Full-rate drain
    load(8, 16'h0001);
    m_ready = 1'b1;
    repeat (12) step();
    chk("A_words", words_out, 8);

    // Backpressure: exactly three reads outstanding, head held
    do_reset();
    fq.delete();
    load(8, 16'h0001);
    m_ready = 1'b0;
    rd_pulses = 0;
    repeat (10) step();
    chk("B_rd_pulses", rd_pulses, 3);
    chk("B_hold", m_data, 16'h0001);
    m_ready = 1'b1;
    repeat (14) step();
    chk("B_words", words_out, 8);

    // Alternating ready
    load(16, 16'h0100);
    for (int c = 0; c < 44; c++) begin
      m_ready = (c % 2 == 0);
      step();
    end
    chk("C_words", words_out, 24);

    // Flush with two buffered and one in flight
    m_ready = 1'b0;
    load(4, 16'h0200);
    repeat (3) step();
    w_before = words_out;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("D_valid_after_flush", m_valid, 0);
    chk("D_words_kept", words_out, w_before);
    wait_cyc = 0;
    while (!m_valid && wait_cyc < 8) begin
      step();
      wait_cyc++;
    end
    chk("D_valid_timeout", m_valid, 1);
    chk("D_next_word", m_data, 16'h0203);
    m_ready = 1'b1;
    repeat (4) step();

    // Random traffic with occasional flushes
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(2) == 0 && fq.size() < 20) fq.push_back(16'($urandom));
      m_ready = ($urandom_range(3) != 0);
      flush   = ($urandom_range(24) == 0);
      step();
    end
    flush = 1'b0;
    m_ready = 1'b1;
    repeat (30) step();

    // Underflow on a returning read
    load(2, 16'h0300);
    uf_inj = 1'b1;
    step();
    uf_inj = 1'b0;
    chk("E_no_capture_valid", m_valid, 0);
    repeat (6) step();
    chk("E_err_sticky", err_underflow, 1);

    // Asynchronous reset with three words buffered
    fq.delete();
    load(8, 16'h0400);
    m_ready = 1'b0;
    repeat (5) step();
    chk("F_full_valid", m_valid, 1);
    #2;
    do_reset();
    m_ready = 1'b1;
    repeat (12) step();
    chk("F_words", words_out, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
